// File: rtl/color_pwm_driver.sv
// Three-channel PWM driver that fades linearly between colour-code targets.
// Latency: code sampled in 1 cycle, FADE entered the cycle after; PWM outputs registered (1-cycle lag).
// Backpressure: none; a code change mid-fade retargets the fade immediately.
module color_pwm_driver #(
    parameter int PWM_WIDTH   = 8,
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] color,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       busy
);
    localparam logic [PWM_WIDTH-1:0] MAX = '1;
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    typedef enum logic {IDLE, FADE} state_t;

    state_t               state, state_nxt;
    logic [1:0]           color_q;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [SW-1:0]        step_cnt, step_nxt;
    logic [PWM_WIDTH-1:0] lvl_r, lvl_g, lvl_b;
    logic [PWM_WIDTH-1:0] lvl_r_nxt, lvl_g_nxt, lvl_b_nxt;
    logic [PWM_WIDTH-1:0] tgt_r, tgt_g, tgt_b;

    function automatic logic [PWM_WIDTH-1:0] step_toward(
        input logic [PWM_WIDTH-1:0] lvl,
        input logic [PWM_WIDTH-1:0] tgt
    );
        if (lvl < tgt)
            return lvl + 1'b1;
        else if (lvl > tgt)
            return lvl - 1'b1;
        else
            return lvl;
    endfunction

    always_comb begin
        tgt_r = '0;
        tgt_g = '0;
        tgt_b = '0;
        case (color_q)
            2'd1:    tgt_b = MAX;
            2'd2:    tgt_r = MAX;
            2'd3: begin
                tgt_r = MAX;
                tgt_g = MAX;
                tgt_b = MAX;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        lvl_r_nxt = lvl_r;
        lvl_g_nxt = lvl_g;
        lvl_b_nxt = lvl_b;
        case (state)
            IDLE: begin
                if (lvl_r != tgt_r || lvl_g != tgt_g || lvl_b != tgt_b) begin
                    state_nxt = FADE;
                    step_nxt  = '0;
                end
            end
            FADE: begin
                if (step_cnt == STEP_LAST) begin
                    step_nxt  = '0;
                    lvl_r_nxt = step_toward(lvl_r, tgt_r);
                    lvl_g_nxt = step_toward(lvl_g, tgt_g);
                    lvl_b_nxt = step_toward(lvl_b, tgt_b);
                    // Leave FADE only once the post-step levels have all landed.
                    if (lvl_r_nxt == tgt_r && lvl_g_nxt == tgt_g && lvl_b_nxt == tgt_b)
                        state_nxt = IDLE;
                end else begin
                    step_nxt = step_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            color_q  <= '0;
            pwm_cnt  <= '0;
            step_cnt <= '0;
            lvl_r    <= '0;
            lvl_g    <= '0;
            lvl_b    <= '0;
            pwm_r    <= 1'b0;
            pwm_g    <= 1'b0;
            pwm_b    <= 1'b0;
        end else begin
            state    <= state_nxt;
            color_q  <= color;
            pwm_cnt  <= pwm_cnt + 1'b1;
            step_cnt <= step_nxt;
            lvl_r    <= lvl_r_nxt;
            lvl_g    <= lvl_g_nxt;
            lvl_b    <= lvl_b_nxt;
            pwm_r    <= (pwm_cnt < lvl_r);
            pwm_g    <= (pwm_cnt < lvl_g);
            pwm_b    <= (pwm_cnt < lvl_b);
        end
    end

    assign busy = (state == FADE);
endmodule

// File: tb/tb_color_pwm_driver.sv
// Scoreboard bench for color_pwm_driver: expected busy pulse lengths and PWM duty
// counts are queued by the stimulus and checked by independent monitors.
module tb_color_pwm_driver;
    logic       clk;
    logic       rst_n;
    logic [1:0] color;
    logic       pwm_r, pwm_g, pwm_b, busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int    r;
        int    g;
        int    b;
        string name;
    } duty_t;

    duty_t duty_q[$];
    int    busy_q[$];

    color_pwm_driver #(.PWM_WIDTH(8), .STEP_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .color (color),
        .pwm_r (pwm_r),
        .pwm_g (pwm_g),
        .pwm_b (pwm_b),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Busy monitor: every completed busy pulse is matched against the next expected length.
    initial begin : busy_mon
        int len;
        int exp_len;
        len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                len = 0;
            end else if (busy) begin
                len++;
            end else if (len > 0) begin
                if (busy_q.size() == 0) begin
                    chk("unexpected_busy_pulse", len, 0);
                end else begin
                    exp_len = busy_q.pop_front();
                    chk("busy_len", len, exp_len);
                end
                len = 0;
            end
        end
    end

    // Duty monitor: counts high cycles over one full 256-cycle PWM period.
    initial begin : duty_mon
        int    cr, cg, cb;
        duty_t d;
        forever begin
            @(negedge clk);
            if (duty_q.size() > 0) begin
                cr = 0; cg = 0; cb = 0;
                for (int i = 0; i < 256; i++) begin
                    if (i > 0) @(negedge clk);
                    cr += int'(pwm_r);
                    cg += int'(pwm_g);
                    cb += int'(pwm_b);
                end
                d = duty_q.pop_front();
                chk({d.name, "_r"}, cr, d.r);
                chk({d.name, "_g"}, cg, d.g);
                chk({d.name, "_b"}, cb, d.b);
            end
        end
    end

    task automatic measure(input string name, input int r, input int g, input int b);
        duty_t d;
        bit    done;
        d.r = r; d.g = g; d.b = b; d.name = name;
        duty_q.push_back(d);
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            #1;
            if (duty_q.size() == 0) done = 1;
        end
        if (!done) begin
            chk({name, "_timeout"}, 1, 0);
            duty_q.delete();
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (busy_q.size() == 0) done = 1;
        end
        if (!done) begin
            chk({name, "_timeout"}, 1, 0);
            busy_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        color = 2'd0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_pwm_r", int'(pwm_r), 0);
        chk("reset_pwm_g", int'(pwm_g), 0);
        chk("reset_pwm_b", int'(pwm_b), 0);
        chk("reset_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Off after reset: no PWM activity, no busy pulse for 600+ cycles.
        measure("off_idle_a", 0, 0, 0);
        measure("off_idle_b", 0, 0, 0);
        repeat (100) @(negedge clk);

        // Red fade-up: busy rises two cycles after the code is driven.
        busy_q.push_back(1020);
        color = 2'd2;
        @(negedge clk);
        chk("busy_before_fade", int'(busy), 0);
        @(negedge clk);
        chk("busy_fade_start", int'(busy), 1);
        wait_idle("red_up");
        repeat (4) @(negedge clk);
        measure("red_full", 255, 0, 0);

        // Fade back down to off.
        busy_q.push_back(1020);
        color = 2'd0;
        wait_idle("red_down");
        repeat (4) @(negedge clk);
        measure("off_again", 0, 0, 0);

        // Red reaches 100 after 400 cycles of fading, then switch to blue.
        // Blue then needs steps 101..355, the last at 1420 cycles after FADE entry.
        busy_q.push_back(1420);
        color = 2'd2;
        repeat (402) @(negedge clk);
        color = 2'd1;
        wait_idle("red_to_blue");
        repeat (4) @(negedge clk);
        measure("blue_full", 0, 0, 255);

        // White: red and green ramp while blue already sits at MAX.
        busy_q.push_back(1020);
        color = 2'd3;
        wait_idle("white_up");
        repeat (4) @(negedge clk);
        measure("white_full", 255, 255, 255);

        // Same code again: no fade at all.
        color = 2'd3;
        repeat (300) @(negedge clk);
        chk("redrive_busy", int'(busy), 0);
        measure("white_redrive", 255, 255, 255);

        // Two down-steps then reverse: two up-steps later FADE ends on the 4th step boundary.
        busy_q.push_back(16);
        color = 2'd0;
        repeat (10) @(negedge clk);
        color = 2'd3;
        wait_idle("reverse");
        repeat (4) @(negedge clk);
        measure("white_restored", 255, 255, 255);

        // Async reset in the middle of a fade.
        color = 2'd0;
        repeat (100) @(negedge clk);
        chk("busy_mid_fade", int'(busy), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pwm_r", int'(pwm_r), 0);
        chk("arst_pwm_g", int'(pwm_g), 0);
        chk("arst_pwm_b", int'(pwm_b), 0);
        chk("arst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure("post_reset_off", 0, 0, 0);
        repeat (50) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);

        chk("busy_queue_drained", busy_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
